// File: rtl/dmem_pipelined.sv
// Pipelined RV32 data memory: byte-lane stores, sign/zero-extended loads,
// misalignment reporting and a one-word-per-cycle clear after reset.
module dmem_pipelined #(
    parameter int MEM_DEPTH = 16,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        rd_req,
    input  logic [31:0] rd_addr0,
    input  logic [2:0]  rd_size,
    output logic        rd_valid,
    output logic [31:0] rd_dout0,
    output logic        rd_err,
    input  logic        we0,
    input  logic [31:0] wr_addr0,
    input  logic [31:0] wr_din0,
    input  logic [2:0]  wr_strb,
    output logic        wr_err
);
    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int NST = RD_LAT + 1;

    typedef enum logic {CLEAR, READY} state_t;

    function automatic logic ld_misaligned(input logic [2:0] sz, input logic [1:0] lane);
        case (sz)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lane[0];
            3'b010:         return |lane;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic st_misaligned(input logic [2:0] sz, input logic [1:0] lane);
        case (sz)
            3'd0:    return 1'b0;
            3'd1:    return lane[0];
            3'd2:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [2:0] sz,
                                               input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (sz)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return word;
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] st_lanes(input logic [2:0] sz, input logic [1:0] lane);
        case (sz)
            3'd0:    return 4'b0001 << lane;
            3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] st_replicate(input logic [31:0] din, input logic [2:0] sz);
        case (sz)
            3'd0:    return {4{din[7:0]}};
            3'd1:    return {2{din[15:0]}};
            default: return din;
        endcase
    endfunction

    state_t          state_q;
    logic [AW-1:0]   ptr_q;
    logic            ready_q;
    logic [31:0]     mem_q [MEM_DEPTH];

    logic [AW-1:0]   rd_idx, wr_idx;
    logic            rd_acc, wr_acc, wr_bad, wr_ok;
    logic [31:0]     ld_data_d;
    logic            ld_err_d;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;

    logic [NST-1:0]  vld_q;
    logic [NST-1:0]  err_q;
    logic [31:0]     dat_q [NST];
    logic            werr_p0_q, wr_err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr0[31:AW+2], wr_addr0[31:AW+2]};

    assign rd_idx    = rd_addr0[2 +: AW];
    assign wr_idx    = wr_addr0[2 +: AW];
    // rst gating drops any access on the same edge as a reset
    assign rd_acc    = rst & ready_q & rd_req;
    assign wr_acc    = rst & ready_q & we0;
    assign wr_bad    = st_misaligned(wr_strb, wr_addr0[1:0]);
    assign wr_ok     = wr_acc & ~wr_bad;
    assign wr_be     = st_lanes(wr_strb, wr_addr0[1:0]);
    assign wr_data   = st_replicate(wr_din0, wr_strb);
    assign ld_err_d  = ld_misaligned(rd_size, rd_addr0[1:0]);
    assign ld_data_d = ld_err_d ? 32'h0 : ld_extract(mem_q[rd_idx], rd_size, rd_addr0[1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == AW'(MEM_DEPTH - 1)) state_q <= READY;
                end
                READY: ready_q <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state_q == CLEAR) begin
            mem_q[ptr_q] <= 32'h0;
        end else if (wr_ok) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Stage 0 holds the read-first array result; later stages only delay it
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q          <= '0;
            err_q          <= '0;
            dat_q[NST-1]   <= 32'h0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= ld_data_d;
                err_q[0] <= ld_err_d;
            end
            for (int k = 1; k < NST; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                    err_q[k] <= err_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            werr_p0_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            werr_p0_q <= wr_acc & wr_bad;
            wr_err_q  <= werr_p0_q;
        end
    end

    assign ready    = ready_q;
    assign rd_valid = vld_q[NST-1];
    assign rd_dout0 = dat_q[NST-1];
    assign rd_err   = err_q[NST-1];
    assign wr_err   = wr_err_q;
endmodule

// File: tb/tb_dmem_pipelined.sv
// Scoreboard bench for dmem_pipelined: a byte-array reference model predicts
// every load result, wr_err pulse and the ready timing.
module tb_dmem_pipelined;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        rd_req;
    logic [31:0] rd_addr0;
    logic [2:0]  rd_size;
    logic        rd_valid;
    logic [31:0] rd_dout0;
    logic        rd_err;
    logic        we0;
    logic [31:0] wr_addr0;
    logic [31:0] wr_din0;
    logic [2:0]  wr_strb;
    logic        wr_err;

    always #5 clk = ~clk;

    dmem_pipelined #(.MEM_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_size(rd_size),
        .rd_valid(rd_valid), .rd_dout0(rd_dout0), .rd_err(rd_err),
        .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0), .wr_strb(wr_strb),
        .wr_err(wr_err)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    rd_exp_t     rq_q[$];
    int          wq[$];
    logic [7:0]  mem_b [BYTES];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          cnt = 0;
    bit          mon_en = 1'b0;

    // cyc = index of the last edge; cnt = consecutive edges with rst high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        cnt <= rst ? cnt + 1 : 0;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic int byte_of(input logic [31:0] a);
        return int'(a & 32'(BYTES - 1));
    endfunction

    function automatic logic [32:0] model_load(input logic [31:0] a, input logic [2:0] sz);
        int b;
        logic [7:0]  by;
        logic [15:0] hw;
        b  = byte_of(a);
        by = mem_b[b];
        case (sz)
            3'b000: return {1'b0, {24{by[7]}}, by};
            3'b100: return {1'b0, 24'h0, by};
            3'b001, 3'b101: begin
                if (b % 2 != 0) return {1'b1, 32'h0};
                hw = {mem_b[b+1], mem_b[b]};
                if (sz[2]) return {1'b0, 16'h0, hw};
                return {1'b0, {16{hw[15]}}, hw};
            end
            3'b010: begin
                if (b % 4 != 0) return {1'b1, 32'h0};
                return {1'b0, mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic bit model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        int b;
        b = byte_of(a);
        case (sz)
            3'd0: mem_b[b] = d[7:0];
            3'd1: begin
                if (b % 2 != 0) return 1'b0;
                mem_b[b] = d[7:0]; mem_b[b+1] = d[15:8];
            end
            3'd2: begin
                if (b % 4 != 0) return 1'b0;
                for (int i = 0; i < 4; i++) mem_b[b+i] = d[8*i +: 8];
            end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic step(input logic r, input logic rq, input logic [31:0] ra, input logic [2:0] rs,
                        input logic w, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [2:0] ws);
        int n;
        logic [32:0] res;
        @(posedge clk);
        #1;
        rst = r; rd_req = rq; rd_addr0 = ra; rd_size = rs;
        we0 = w; wr_addr0 = wa; wr_din0 = wd; wr_strb = ws;
        n = cyc + 1;
        if (!r) begin
            while (rq_q.size() > 0 && rq_q[$].due >= n) void'(rq_q.pop_back());
            while (wq.size() > 0 && wq[$] >= n) void'(wq.pop_back());
            for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h00;
        end else if (cnt > DEPTH) begin
            if (rq) begin
                res = model_load(ra, rs);
                rq_q.push_back(rd_exp_t'{due: n + LAT, data: res[31:0], err: res[32]});
            end
            if (w && !model_store(wa, wd, ws)) wq.push_back(n + 1);
        end
    endtask

    task automatic idle(input logic r, input int k);
        for (int i = 0; i < k; i++) step(r, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 3'd0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] sz);
        step(1'b1, 1'b1, a, sz, 1'b0, 32'h0, 32'h0, 3'd0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, a, d, sz);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit      exp_we;
            rd_exp_t e;
            chk("ready", {31'h0, ready}, {31'h0, cnt > DEPTH});
            exp_we = (wq.size() > 0 && wq[0] == cyc);
            if (exp_we) void'(wq.pop_front());
            chk("wr_err", {31'h0, wr_err}, {31'h0, exp_we});
            if (rd_valid) begin
                if (rq_q.size() == 0) begin
                    chk("rd_valid_unexpected", 32'h1, 32'h0);
                end else begin
                    e = rq_q.pop_front();
                    chk("rd_valid_cycle", cyc, e.due);
                    chk("rd_dout0", rd_dout0, e.data);
                    chk("rd_err", {31'h0, rd_err}, {31'h0, e.err});
                end
            end else if (rq_q.size() > 0 && rq_q[0].due <= cyc) begin
                e = rq_q.pop_front();
                chk("rd_valid_missing", 32'h0, 32'h1);
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  rs, ws;
        logic [2:0]  sz_tab [8];
        sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd2, 3'd3};
        rst = 1'b0; rd_req = 1'b0; rd_addr0 = '0; rd_size = '0;
        we0 = 1'b0; wr_addr0 = '0; wr_din0 = '0; wr_strb = '0;
        for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h00;
        mon_en = 1'b1;
        idle(1'b0, 3);
        @(negedge clk);
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("reset_rd_dout0", rd_dout0, 32'h0);
        chk("reset_rd_err", {31'h0, rd_err}, 32'h0);

        // accesses during the clear must be ignored
        step(1'b1, 1'b1, 32'h4, 3'd2, 1'b1, 32'h4, 32'hDEADBEEF, 3'd2);
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h5, 32'h0, 3'd1);
        idle(1'b1, 18);
        for (int i = 0; i < DEPTH; i++) ld(32'(4 * i), 3'd2);

        st(32'h8, 32'h11223344, 3'd2);
        st(32'h9, 32'h000000AA, 3'd0);
        st(32'hA, 32'h0000BEEF, 3'd1);
        ld(32'h8, 3'd2); ld(32'h9, 3'd0); ld(32'h9, 3'd4); ld(32'hA, 3'd5);

        st(32'h4, 32'hCAFEF00D, 3'd2);
        st(32'h5, 32'h12345678, 3'd1);
        st(32'h6, 32'h87654321, 3'd2);
        st(32'h4, 32'h0000FFFF, 3'd3);
        ld(32'h4, 3'd2); ld(32'h2, 3'd2); ld(32'h1, 3'd1); ld(32'h4, 3'd3); ld(32'h4, 3'd7);

        st(32'h0, 32'h1, 3'd2);
        step(1'b1, 1'b1, 32'h0, 3'd2, 1'b1, 32'h0, 32'h5, 3'd2);
        ld(32'h0, 3'd2);
        ld(32'h40, 3'd2);
        st(32'h44, 32'hA5A5A5A5, 3'd2);
        ld(32'h4, 3'd2);
        idle(1'b1, 5);

        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            rs = sz_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d  = $urandom;
            ws = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) ws = 3'($urandom_range(3, 7));
            step(1'b1, 1'($urandom_range(0, 1)), a, rs, 1'($urandom_range(0, 1)),
                 {$urandom, 2'b00} | 32'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0),
                 d, ws);
        end
        idle(1'b1, 8);

        st(32'hC, 32'h12345678, 3'd2);
        ld(32'hC, 3'd2);
        ld(32'h8, 3'd2);
        step(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 32'hC, 32'hFFFFFFFF, 3'd2);
        idle(1'b1, 20);
        for (int i = 0; i < DEPTH; i++) ld(32'(4 * i), 3'd2);
        idle(1'b1, 8);

        @(negedge clk);
        chk("rd_queue_drained", rq_q.size(), 32'h0);
        chk("wr_err_queue_drained", wq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
